// File: rtl/data_mem_responder.sv
// Data-memory responder: services load/store requests from the pipeline after
// WAIT_CYCLES wait states, with byte-lane stores, extended loads and fault flagging.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        access_fault
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, next_state;
  logic [3:0] wait_cnt, next_cnt;

  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [1:0]            lat_off;
  logic [2:0]            lat_f3;
  logic [31:0]           lat_wdata;
  logic                  lat_store;

  logic [31:0] mem [DEPTH];

  logic request, bad_req, accept;
  logic [ADDR_WIDTH-1:0] eff_idx;
  logic [1:0]  eff_off;
  logic [2:0]  eff_f3;
  logic        eff_store;
  logic [31:0] load_word, load_shift, load_val;
  logic [15:0] load_half;
  logic [3:0]  store_be;
  logic [31:0] store_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];
  assign request = mem_read | mem_write;

  // Fault rules: illegal encodings, store-only restrictions, then alignment
  always_comb begin
    bad_req = 1'b0;
    case (funct3)
      3'b000:  bad_req = 1'b0;
      3'b001:  bad_req = addr[0];
      3'b010:  bad_req = (addr[1:0] != 2'b00);
      3'b100:  bad_req = mem_write;
      3'b101:  bad_req = mem_write | addr[0];
      default: bad_req = 1'b1;
    endcase
  end

  assign accept       = (state == IDLE) && request && !bad_req;
  assign stall        = rst_n && ((state == WAIT) || accept);
  assign access_fault = rst_n && (state == IDLE) && request && bad_req;

  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          next_cnt   = CNT_INIT;
          next_state = (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) next_state = DONE;
        else                  next_cnt   = wait_cnt - 4'd1;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Live inputs in the acceptance cycle (needed when WAIT_CYCLES is 0), latched copy afterwards
  assign eff_idx   = (state == IDLE) ? addr[ADDR_WIDTH+1:2] : lat_idx;
  assign eff_off   = (state == IDLE) ? addr[1:0] : lat_off;
  assign eff_f3    = (state == IDLE) ? funct3 : lat_f3;
  assign eff_store = (state == IDLE) ? mem_write : lat_store;

  assign load_word  = mem[eff_idx];
  assign load_shift = load_word >> {eff_off, 3'b000};
  assign load_half  = eff_off[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_val = load_word;
    case (eff_f3)
      3'b000:  load_val = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {24'd0, load_shift[7:0]};
      3'b101:  load_val = {16'd0, load_half};
      default: load_val = load_word;
    endcase
  end

  always_comb begin
    store_be   = 4'b1111;
    store_word = lat_wdata;
    case (lat_f3[1:0])
      2'b00: begin
        store_be   = 4'b0001 << lat_off;
        store_word = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        store_be   = lat_off[1] ? 4'b1100 : 4'b0011;
        store_word = {2{lat_wdata[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_word = lat_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rdata     <= 32'd0;
      lat_idx   <= '0;
      lat_off   <= 2'd0;
      lat_f3    <= 3'd0;
      lat_wdata <= 32'd0;
      lat_store <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      if (accept) begin
        lat_idx   <= addr[ADDR_WIDTH+1:2];
        lat_off   <= addr[1:0];
        lat_f3    <= funct3;
        lat_wdata <= wdata;
        lat_store <= mem_write;
      end
      if (access_fault)
        rdata <= 32'd0;
      else if (next_state == DONE && state != DONE && !eff_store)
        rdata <= load_val;
    end
  end

  // Stores commit on the edge that closes DONE; a reset on that edge drops them
  always_ff @(posedge clk) begin
    if (rst_n && state == DONE && lat_store) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) mem[lat_idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two builds (WAIT_CYCLES 1 and 0) checked against
// a byte-addressed reference memory with directed and randomized accesses.
module tb_data_mem_responder;

  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;
  localparam int NBYTE = DEPTH * 4;

  logic        clk;
  logic        rst_n;
  logic        mr [2];
  logic        mw [2];
  logic [2:0]  f3 [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd_o [2];
  logic        st [2];
  logic        af [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  mbytes [2][NBYTE];
  logic [31:0] last_rdata [2];

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read(mr[0]), .mem_write(mw[0]), .funct3(f3[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rd_o[0]), .stall(st[0]), .access_fault(af[0])
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(mr[1]), .mem_write(mw[1]), .funct3(f3[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rd_o[1]), .stall(st[1]), .access_fault(af[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int wc(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int access_size(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_fault(input bit wr, input logic [2:0] f, input logic [31:0] a);
    int size;
    size = access_size(f);
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
    if (wr && f >= 3'd4) return 1'b1;
    if ((a % size) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [2:0] f, input logic [31:0] a);
    int size, base;
    longint v;
    size = access_size(f);
    base = int'(a % NBYTE);
    v = 0;
    for (int i = 0; i < size; i++) v = v | (longint'(mbytes[d][base + i]) << (8 * i));
    if (!f[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  task automatic model_store(input int d, input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    int size, base;
    logic [31:0] sh;
    size = access_size(f);
    base = int'(a % NBYTE);
    for (int i = 0; i < size; i++) begin
      sh = w >> (8 * i);
      mbytes[d][base + i] = sh[7:0];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int d = 0; d < 2; d++) begin
      mr[d] = 1'b0;
      mw[d] = 1'b0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full access on DUT d; on return after a legal access the request is still
  // asserted in the IDLE cycle so a following call exercises back-to-back acceptance.
  task automatic applyStimulus(input int d, input bit rd, input bit wr, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] w);
    int n;
    mr[d] = rd;
    mw[d] = wr;
    f3[d] = f;
    ad[d] = a;
    wd[d] = w;
    #1;
    if (model_fault(wr, f, a)) begin
      checkOutput("fault_flag", {31'd0, af[d]}, 32'd1);
      checkOutput("fault_stall", {31'd0, st[d]}, 32'd0);
      @(posedge clk);
      #1;
      mr[d] = 1'b0;
      mw[d] = 1'b0;
      #1;
      last_rdata[d] = 32'd0;
      checkOutput("fault_rdata", rd_o[d], 32'd0);
      checkOutput("fault_clear", {31'd0, af[d]}, 32'd0);
    end else begin
      checkOutput("accept_stall", {31'd0, st[d]}, 32'd1);
      checkOutput("accept_nofault", {31'd0, af[d]}, 32'd0);
      n = 1;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (!st[d]) break;
        n++;
      end
      checkOutput("stall_cycles", n, wc(d) + 1);
      if (!wr) last_rdata[d] = model_load(d, f, a);
      checkOutput("done_rdata", rd_o[d], last_rdata[d]);
      @(posedge clk);
      #1;
      if (wr) model_store(d, f, a, w);
    end
  endtask

  initial begin
    logic [31:0] r, a;
    int idx, off, op;
    logic [2:0] f;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mr[d] = 1'b0; mw[d] = 1'b0; f3[d] = 3'd0; ad[d] = 32'd0; wd[d] = 32'd0;
      last_rdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_rdata", rd_o[d], 32'd0);
      checkOutput("reset_stall", {31'd0, st[d]}, 32'd0);
      checkOutput("reset_fault", {31'd0, af[d]}, 32'd0);
    end
    rst_n = 1'b1;
    idleCycles(1);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) applyStimulus(d, 1'b0, 1'b1, 3'b010, i * 4, $urandom());
      idleCycles(1);
    end

    $display("[TB] directed accesses, WAIT_CYCLES=1");
    applyStimulus(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    idleCycles(1);
    applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0);
    idleCycles(1);
    applyStimulus(0, 0, 1, 3'b000, 32'h11, 32'h000000A5);
    applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0);
    checkOutput("sb_word", rd_o[0], 32'hDEADA5EF);
    applyStimulus(0, 1, 0, 3'b000, 32'h11, 32'h0);
    checkOutput("lb_sign", rd_o[0], 32'hFFFFFFA5);
    applyStimulus(0, 1, 0, 3'b100, 32'h11, 32'h0);
    checkOutput("lbu_zero", rd_o[0], 32'h000000A5);
    applyStimulus(0, 1, 0, 3'b001, 32'h12, 32'h0);
    checkOutput("lh_sign", rd_o[0], 32'hFFFFDEAD);
    idleCycles(1);

    applyStimulus(0, 1, 0, 3'b010, 32'h13, 32'h0);
    applyStimulus(0, 0, 1, 3'b001, 32'h11, 32'h0000BEEF);
    applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0);
    checkOutput("sh_fault_nowrite", rd_o[0], 32'hDEADA5EF);
    idleCycles(1);
    applyStimulus(0, 1, 0, 3'b011, 32'h10, 32'h0);
    applyStimulus(0, 0, 1, 3'b100, 32'h10, 32'h0);
    idleCycles(1);

    applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0);
    applyStimulus(0, 1, 1, 3'b010, 32'h20, 32'h12345678);
    checkOutput("rdwr_rdata_held", rd_o[0], 32'hDEADA5EF);
    applyStimulus(0, 1, 0, 3'b010, 32'h20, 32'h0);
    checkOutput("rdwr_stored", rd_o[0], 32'h12345678);
    applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0);
    idleCycles(1);

    $display("[TB] reset during WAIT");
    mr[0] = 1'b0; mw[0] = 1'b1; f3[0] = 3'b010; ad[0] = 32'h30; wd[0] = 32'hCAFEF00D;
    #1;
    checkOutput("midrst_accept", {31'd0, st[0]}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_stall", {31'd0, st[0]}, 32'd0);
      checkOutput("midrst_rdata", rd_o[0], 32'd0);
    end
    checkOutput("midrst_rdata_other", rd_o[1], 32'd0);
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    mw[0] = 1'b0;
    rst_n = 1'b1;
    idleCycles(1);
    applyStimulus(0, 1, 0, 3'b010, 32'h30, 32'h0);
    idleCycles(1);

    $display("[TB] WAIT_CYCLES=0 and address wrap");
    applyStimulus(1, 1, 0, 3'b010, 32'h10, 32'h0);
    idleCycles(1);
    applyStimulus(1, 0, 1, 3'b010, (32'd4 << AW) + 32'h8, 32'hA1B2C3D4);
    applyStimulus(1, 1, 0, 3'b010, 32'h8, 32'h0);
    checkOutput("wrap_alias", rd_o[1], 32'hA1B2C3D4);
    idleCycles(1);

    $display("[TB] randomized accesses");
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        r   = $urandom();
        idx = $urandom_range(0, 15);
        off = $urandom_range(0, 3);
        op  = $urandom_range(0, 2);
        f   = 3'($urandom_range(0, 7));
        a   = (r & 32'hFFFFFF00) | (idx << 2) | off;
        applyStimulus(d, op != 1, op != 0, f, a, $urandom());
        if ($urandom_range(0, 1) == 1) idleCycles(1);
      end
      idleCycles(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
